// File: rtl/noc_inject_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_inject_queue_pkg
//  Purpose  : Shared NoC types for the tile injection path. This package holds
//             the tile identifier type, the broadcast destination marker and
//             the queued message layout {dst, data}.
//  Ports    : none (package)
//  Config   : NOC_INJECT_BCAST_EN (in noc_inject_queue) gives BCAST_ID its
//             broadcast meaning. Without it, BCAST_ID is an ordinary tile ID.
//  Revision : 1.0  initial release
// ============================================================================
package noc_inject_queue_pkg;

    // NoC payload width. Matches tile_noc DATA_WIDTH.
    localparam int NOC_DATA_WIDTH = 32;

    // Wide enough for up to 16 tiles.
    localparam int TILE_ID_WIDTH  = 4;

    typedef logic [TILE_ID_WIDTH-1:0] tile_id_t;

    // All-ones destination marks a broadcast when the feature is built in.
    localparam tile_id_t BCAST_ID = '1;

    typedef struct packed {
        tile_id_t                  dst;
        logic [NOC_DATA_WIDTH-1:0] data;
    } noc_msg_t;

endpackage : noc_inject_queue_pkg
`default_nettype wire

// File: rtl/noc_inject_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : noc_inject_queue_if
//  Purpose  : Valid/ready message stream carrying a destination tile and a
//             payload. The same interface is used for the producer side and
//             for the NoC side of the injection queue.
//  Signals  : valid (master->slave), ready (slave->master),
//             dst   (tile_id_t destination / NoC port),
//             data  (DATA_WIDTH payload)
//  Modports : master drives valid/dst/data. slave drives ready.
//  Revision : 1.0  initial release
// ============================================================================
interface noc_inject_queue_if
    import noc_inject_queue_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH
) ();

    logic                  valid;
    logic                  ready;
    tile_id_t              dst;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output dst,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  dst,
        input  data,
        output ready
    );

endinterface : noc_inject_queue_if
`default_nettype wire

// File: rtl/noc_inject_queue_msg_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : noc_msg_fifo
//  Purpose  : Circular message store for noc_inject_queue. It holds the
//             pointers and the occupancy count. The caller never pushes when
//             the store is full and never pops when it is empty.
//  Ports    : clk, rstn       clock, synchronous active-low reset
//             push, push_msg  write push_msg at tail
//             pop             retire the entry at head
//             next_msg        entry one behind head; it becomes the new head
//                             after a pop
//             count           entries held, 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module noc_msg_fifo
    import noc_inject_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rstn,
    input  wire logic                     push,
    input  wire noc_msg_t                 push_msg,
    input  wire logic                     pop,
    output noc_msg_t                      next_msg,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    noc_msg_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    w_rd_ptr_inc;

    // DEPTH is a power of two, so pointer wrap is natural rollover.
    assign w_rd_ptr_inc = r_rd_ptr + c_PTR_W'(1);
    assign next_msg     = r_mem[w_rd_ptr_inc];
    assign count        = r_count;

    // Storage is not reset. Resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : noc_msg_fifo
`default_nettype wire

// File: rtl/noc_inject_queue.sv
`default_nettype none
// ============================================================================
//  Module   : noc_inject_queue
//  Purpose  : Per-tile injection buffer in front of one tile_noc slave port.
//             A DEPTH-entry FIFO decouples the producer from NoC backpressure.
//             A registered head presents a stable valid/ready stream.
//  Ports    : clk        clock
//             rstn       synchronous active-low reset
//             in_if      slave  : in_valid/in_ready/in_dst/in_data
//                        (in_ready is registered)
//             out_if     master : out_valid/out_ready/out_port/out_data
//                        (to s_wvalid/s_wready/s_port/s_wdata[SELF_ID])
//             occupancy  messages held, including the presented one
//  Config   : NOC_INJECT_BCAST_EN - a message addressed to BCAST_ID is sent
//             once to every tile except SELF_ID, with ports in ascending
//             order. Without the macro, BCAST_ID is forwarded as a single
//             message and the FSM only ever uses IDLE and SEND.
//  Revision : 1.0  initial release
// ============================================================================
module noc_inject_queue
    import noc_inject_queue_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int N_TILES    = 16,
    parameter int SELF_ID    = 0
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    noc_inject_queue_if.slave       in_if,
    noc_inject_queue_if.master      out_if,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT   = c_CNT_W'(1);

`ifdef NOC_INJECT_BCAST_EN
    localparam bit c_BCAST_EN = 1'b1;
`else
    localparam bit c_BCAST_EN = 1'b0;
`endif

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SEND  = 2'd1;
    localparam logic [1:0] c_BCAST = 2'd2;

    // Broadcast port range. The skipped tile is SELF_ID. When SELF_ID is at
    // either end of the range, the first or last port moves inward.
    localparam tile_id_t c_SELF       = tile_id_t'(SELF_ID);
    localparam tile_id_t c_FIRST_PORT = tile_id_t'((SELF_ID == 0) ? 1 : 0);
    localparam tile_id_t c_LAST_PORT  =
        tile_id_t'((SELF_ID == N_TILES - 1) ? N_TILES - 2 : N_TILES - 1);

    logic [1:0]            r_state;
    tile_id_t              r_out_port;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_in_ready;

    logic                  w_push;
    logic                  w_xfer;
    logic                  w_pop;
    logic [c_CNT_W-1:0]    w_count_nxt;
    noc_msg_t              w_in_msg;
    noc_msg_t              w_fifo_next;
    noc_msg_t              w_next_msg;
    noc_msg_t              w_load_msg;
    logic                  w_load;
    logic [1:0]            w_state_nxt;
    tile_id_t              w_port_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    tile_id_t              w_port_inc;
    tile_id_t              w_port_step;

    assign w_in_msg.dst  = in_if.dst;
    assign w_in_msg.data = in_if.data;

    assign in_if.ready   = r_in_ready;
    assign out_if.valid  = (r_state != c_IDLE);
    assign out_if.dst    = r_out_port;
    assign out_if.data   = r_out_data;

    assign w_push = in_if.valid && r_in_ready;
    assign w_xfer = out_if.valid && out_if.ready;

    // A broadcast entry is retired only when its final copy transfers.
    assign w_pop  = w_xfer &&
                    ((r_state == c_SEND) ||
                     ((r_state == c_BCAST) && (r_out_port == c_LAST_PORT)));

    assign w_count_nxt = occupancy + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    // The head register stays one entry ahead of the FIFO read pointer.
    // When only the presented entry is left, the next head can only be a
    // message arriving at this same edge.
    assign w_next_msg = (occupancy > c_ONE_CNT) ? w_fifo_next : w_in_msg;

    assign w_port_inc  = r_out_port + tile_id_t'(1);
    assign w_port_step = (w_port_inc == c_SELF) ? (w_port_inc + tile_id_t'(1))
                                                : w_port_inc;

    noc_msg_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (w_push),
        .push_msg (w_in_msg),
        .pop      (w_pop),
        .next_msg (w_fifo_next),
        .count    (occupancy)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_out_port;
        w_data_nxt  = r_out_data;
        w_load      = 1'b0;
        w_load_msg  = w_in_msg;

        case (r_state)
            c_IDLE: begin
                // An empty queue presents a new message right after the push
                // edge. The same edge also writes it into the FIFO.
                if (w_push) begin
                    w_load = 1'b1;
                end
            end
            c_SEND, c_BCAST: begin
                if (w_pop) begin
                    if (w_count_nxt != '0) begin
                        w_load     = 1'b1;
                        w_load_msg = w_next_msg;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else if (w_xfer && (r_state == c_BCAST)) begin
                    w_port_nxt = w_port_step;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        if (w_load) begin
            w_data_nxt = w_load_msg.data;
            if (c_BCAST_EN && (w_load_msg.dst == BCAST_ID)) begin
                w_state_nxt = c_BCAST;
                w_port_nxt  = c_FIRST_PORT;
            end else begin
                w_state_nxt = c_SEND;
                w_port_nxt  = w_load_msg.dst;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= c_IDLE;
            r_out_port <= '0;
            r_out_data <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_out_port <= w_port_nxt;
            r_out_data <= w_data_nxt;
            // in_ready is registered, so a pop at full opens the input only
            // on the following cycle.
            r_in_ready <= (w_count_nxt < c_DEPTH_CNT);
        end
    end

endmodule : noc_inject_queue
`default_nettype wire

// File: doc/noc_inject_queue.md
Name: noc_inject_queue

Overview:
- Per-tile injection buffer that feeds one slave port of tile_noc (s_wvalid/s_wready/s_port/s_wdata).
- Decouples the tile's message producer from NoC backpressure with a DEPTH-entry FIFO of {dst, data}.
- Presents a stable, AXI-style valid/ready stream to the NoC, and optionally expands broadcast messages into N_TILES-1 unicasts.

Parameters:
- DATA_WIDTH, 32, payload width; matches tile_noc DATA_WIDTH.
- DEPTH, 8, FIFO capacity in messages; power of 2, >= 2.
- N_TILES, 16, number of tiles on the NoC.
- SELF_ID, 0, tile_id_t of the owning tile; skipped during broadcast.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- in_valid  in  1  producer has a message.
- in_ready  out  1  queue can accept; registered.
- in_dst  in  tile_id_t  destination tile.
- in_data  in  DATA_WIDTH  payload.
- out_valid  out  1  to tile_noc s_wvalid[SELF_ID].
- out_ready  in  1  from tile_noc s_wready[SELF_ID].
- out_port  out  tile_id_t  to s_port[SELF_ID].
- out_data  out  DATA_WIDTH  to s_wdata[SELF_ID].
- occupancy  out  $clog2(DEPTH)+1  messages held, including the one being presented.

Behaviour:
- Reset (rstn low at a clk edge): out_valid=0, in_ready=0, occupancy=0, out_port=0, out_data=0, pointers=0, FSM=IDLE. All contents are discarded, including when reset arrives mid-operation. in_ready rises on the first edge after rstn returns high.
- Push: in_valid && in_ready at an edge writes {in_dst, in_data} at tail. Tail wraps DEPTH-1 -> 0.
- in_ready = (occupancy < DEPTH), computed from registered state only. There is no combinational path from out_ready to in_ready.
- Full: in_ready=0. A simultaneous pop at full does not admit a push in the same cycle.
- Latency: with the queue empty, a message pushed at edge N drives out_valid=1 after edge N. No same-cycle bypass.
- Output: out_port/out_data are registered from head. Once out_valid=1, out_valid/out_port/out_data hold until out_ready is sampled high.
- Pop: out_valid && out_ready at an edge completes the transfer. The next head is presented after that edge with no bubble. Head wraps DEPTH-1 -> 0.
- Back-to-back: with sustained out_ready=1, one message per cycle.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Empty: out_valid=0; out_port/out_data hold their last values.
- occupancy: counter of entries not yet popped (including the presented entry). It is incremented/decremented at the edge; never exceeds DEPTH; never underflows.
- FSM states:
  - IDLE: empty; -> SEND on push.
  - SEND: presenting a unicast head; on pop -> SEND if more entries remain, else IDLE; -> BCAST if the next head is broadcast (feature only).
  - BCAST: see Optional Feature.
- Without the feature, the FSM has only IDLE and SEND.

Optional Feature:
- Macro: NOC_INJECT_BCAST_EN.
- With macro defined, BCAST_ID (all-ones tile_id_t) marks a broadcast.
  - In BCAST, the head is presented repeatedly with out_port stepping 0..N_TILES-1, skipping SELF_ID. Same out_data each time.
  - Each step advances only on out_ready.
  - The entry is popped and occupancy decremented only after the last copy transfers.
  - If SELF_ID is N_TILES-1, the last copy is N_TILES-2.
- Without macro: BCAST_ID is an ordinary destination value and is forwarded unchanged as one message.

Decomposition:
- chronos package (existing): tile_id_t.
- Add to chronos package: BCAST_ID constant and noc_msg_t packed struct {tile_id_t dst; logic [DATA_WIDTH-1:0] data} (width via package DATA_WIDTH constant).
- Sub-module noc_msg_fifo: storage, pointers, count. noc_inject_queue adds the output register, FSM and broadcast counter.

Test Plan:
- Single message: reset, push dst=1 data=0xFFFFFFFF with out_ready=1 -> out_valid=1 one cycle after push, out_port=1, out_data=0xFFFFFFFF, occupancy 1 -> 0.
- Backpressure: push 3 messages (data 0xA0, 0xA1, 0xA2), out_ready=0 for 10 cycles -> out_valid=1, out_data=0xA0 stable throughout; then out_ready=1 -> 0xA0, 0xA1, 0xA2 on three consecutive cycles.
- Full: out_ready=0, push 9 messages with DEPTH=8 -> in_ready=0 after 8th; 9th not accepted; occupancy=8; raise out_ready -> in_ready=1 one cycle after first pop.
- Streaming plus wrap: out_ready=1, push 20 messages back-to-back, data=i -> all received in order 0..19 at one per cycle after initial latency; occupancy <= 1.
- Reset mid-operation: 5 queued, out_ready=0, assert rstn low one cycle -> out_valid=0, occupancy=0; no stale data after rstn release.
- Broadcast (NOC_INJECT_BCAST_EN, SELF_ID=0, N_TILES=16): push dst=BCAST_ID data=0x55 -> 15 transfers, out_port 1..15, each with data 0x55; occupancy drops to 0 only after port 15. Without the macro: one transfer with out_port=BCAST_ID.
